// File: rtl/timer_control_multi.sv
// NDIG-digit BCD event timer: edit a preset with front-panel buttons, arm it,
// and hold S high for preset x TICK_DIV clocks after each evento edge.
module timer_control_multi #(
    parameter int NDIG        = 2,
    parameter int TICK_DIV    = 60000,
    parameter bit RETRIG      = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_campo,
    input  logic                btn_set,
    input  logic                btn_dec,
    input  logic                btn_enable,
    input  logic                evento,
    output logic                S,
    output logic [7*NDIG-1:0]   seg,
    output logic [NDIG-1:0]     led_campo,
    output logic                led_estado,
    output logic                busy
);

    localparam int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {EDIT, ARMED, RUNNING} state_t;
    typedef logic [NDIG-1:0][3:0] bcd_t;

    state_t             state;
    bcd_t               preset;
    bcd_t               remaining;
    logic [SEL_W-1:0]   sel;
    logic [PRE_W-1:0]   prescaler;

    logic [4:0] btn_cur;
    logic [4:0] btn_prev;
    logic [4:0] rise;
    logic       campo_rise, set_rise, dec_rise, enable_rise, evento_rise;

    // One registered sample per input, then compare against the previous sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_cur  <= '0;
            btn_prev <= '0;
        end else begin
            btn_cur  <= {evento, btn_enable, btn_dec, btn_set, btn_campo};
            btn_prev <= btn_cur;
        end
    end

    assign rise        = btn_cur & ~btn_prev;
    assign campo_rise  = rise[0];
    assign set_rise    = rise[1];
    assign dec_rise    = rise[2];
    assign enable_rise = rise[3];
    assign evento_rise = rise[4];

    function automatic logic [3:0] digit_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] v);
        return (v == 4'd0 || v > 4'd9) ? 4'd9 : v - 4'd1;
    endfunction

    // Borrow ripples from the least significant digit (index NDIG-1) upwards
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        logic borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (borrow) begin
                if (v[d] == 4'd0) begin
                    r[d] = 4'd9;
                end else begin
                    r[d]   = v[d] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_is_one(input bcd_t v);
        logic one;
        one = (v[NDIG-1] == 4'd1);
        for (int d = 0; d < NDIG - 1; d++) begin
            if (v[d] != 4'd0) one = 1'b0;
        end
        return one;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EDIT;
            preset     <= '0;
            remaining  <= '0;
            sel        <= '0;
            prescaler  <= '0;
            S          <= 1'b0;
            led_estado <= 1'b0;
        end else begin
            case (state)
                EDIT: begin
                    for (int d = 0; d < NDIG; d++) begin
                        if (sel == SEL_W'(d)) begin
                            if (set_rise && !dec_rise)
                                preset[d] <= digit_inc(preset[d]);
                            else if (dec_rise && !set_rise)
                                preset[d] <= digit_dec(preset[d]);
                        end
                    end
                    if (campo_rise)
                        sel <= (sel == SEL_W'(NDIG - 1)) ? '0 : sel + 1'b1;
                    if (enable_rise) begin
                        state      <= ARMED;
                        led_estado <= 1'b1;
                    end
                end
                ARMED: begin
                    if (enable_rise) begin
                        state      <= EDIT;
                        led_estado <= 1'b0;
                    end else if (evento_rise && preset != '0) begin
                        state     <= RUNNING;
                        remaining <= preset;
                        prescaler <= '0;
                        S         <= 1'b1;
                    end
                end
                RUNNING: begin
                    // Abort beats retrigger, and retrigger beats a coincident tick
                    if (enable_rise) begin
                        state      <= EDIT;
                        led_estado <= 1'b0;
                        S          <= 1'b0;
                        prescaler  <= '0;
                    end else if (RETRIG && evento_rise) begin
                        remaining <= preset;
                        prescaler <= '0;
                    end else if (prescaler == PRE_W'(TICK_DIV - 1)) begin
                        prescaler <= '0;
                        if (bcd_is_one(remaining)) begin
                            remaining <= '0;
                            S         <= 1'b0;
                            state     <= ARMED;
                        end else begin
                            remaining <= bcd_dec(remaining);
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state      <= EDIT;
                    S          <= 1'b0;
                    led_estado <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        seg       = '0;
        led_campo = '0;
        for (int d = 0; d < NDIG; d++) begin
            seg[7*(NDIG-1-d) +: 7] = seg7((state == RUNNING) ? remaining[d] : preset[d])
                                     ^ {7{SEG_ACT_LOW}};
            if (state == EDIT && sel == SEL_W'(d))
                led_campo[NDIG-1-d] = 1'b1;
        end
    end

    assign busy = (state == RUNNING);

endmodule
